// File: rtl/v_mult_pkg.sv
// Shared constants and helpers for the multiply-add/subtract pipeline.
// Saturation values are sliced down to the instance's result width by the user.
`timescale 1ns/1ps
package v_mult_pkg;

    localparam int unsigned MinStages = 1;
    localparam int unsigned MaxStages = 4;

    // Widest result the saturation constants can cover.
    localparam int unsigned MaxRw = 64;

    localparam logic [MaxRw-1:0] SatOnes = {MaxRw{1'b1}};
    localparam logic [MaxRw-1:0] SatZero = {MaxRw{1'b0}};

    typedef enum logic {
        OpSub = 1'b0,
        OpAdd = 1'b1
    } op_e;

    function automatic logic stages_legal(input int unsigned n);
        return (n >= MinStages) && (n <= MaxStages);
    endfunction

endpackage

// File: rtl/v_pipe_delay.sv
// Fixed-depth register delay line; every stage clears on asynchronous reset.
`timescale 1ns/1ps
module v_pipe_delay #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[Depth-1];

endmodule

// File: rtl/v_mult_addsub_pipe.sv
// Pipelined unsigned multiply then add/subtract into a result/accumulator register.
// Define V_MULT_ADDSUB_SAT_EN to clamp RES on carry/borrow instead of wrapping.
`timescale 1ns/1ps
module v_mult_addsub_pipe
    import v_mult_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned BW        = 8,
    parameter int unsigned RW        = 16,
    parameter int unsigned IN_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          add_sub,
    input  logic          accum,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic [RW-1:0] C,
    output logic          out_valid,
    output logic [RW-1:0] RES,
    output logic          ovf
);

    localparam int unsigned PW   = AW + BW;
    localparam int unsigned BusW = 3 + RW + PW;

    if (!stages_legal(IN_STAGES)) begin : g_bad_stages
        $error("IN_STAGES out of range");
    end
    if (RW < PW || RW > MaxRw) begin : g_bad_rw
        $error("RW must satisfy AW+BW <= RW <= MaxRw");
    end

    logic [BusW-1:0] bus_in;
    logic [BusW-1:0] bus_dly;

    // Control and data share one delay line so they cannot drift apart.
    assign bus_in = {in_valid, add_sub, accum, C, B, A};

    v_pipe_delay #(
        .Width (BusW),
        .Depth (IN_STAGES)
    ) u_delay (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .data_i (bus_in),
        .data_o (bus_dly)
    );

    logic          vld_s;
    logic          add_sub_s;
    logic          accum_s;
    logic [RW-1:0] c_s;
    logic [BW-1:0] b_s;
    logic [AW-1:0] a_s;

    assign {vld_s, add_sub_s, accum_s, c_s, b_s, a_s} = bus_dly;

    logic [PW-1:0] prod;
    logic [RW:0]   prod_ext;
    logic [RW:0]   addend;
    logic [RW:0]   sum;
    logic [RW-1:0] res_next;

    logic [RW-1:0] res_q, res_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;

    assign prod     = a_s * b_s;
    assign prod_ext = {{(RW + 1 - PW){1'b0}}, prod};
    assign addend   = accum_s ? {1'b0, res_q} : {1'b0, c_s};
    assign sum      = (op_e'(add_sub_s) == OpAdd) ? (addend + prod_ext) : (addend - prod_ext);

    always_comb begin
        res_next = sum[RW-1:0];
`ifdef V_MULT_ADDSUB_SAT_EN
        if (sum[RW]) begin
            res_next = (op_e'(add_sub_s) == OpAdd) ? SatOnes[RW-1:0] : SatZero[RW-1:0];
        end
`endif
    end

    // Bubbles leave RES/ovf untouched so accumulation survives gaps.
    always_comb begin
        res_d       = res_q;
        ovf_d       = ovf_q;
        out_valid_d = vld_s;
        if (vld_s) begin
            res_d = res_next;
            ovf_d = sum[RW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign RES       = res_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_v_mult_addsub_pipe.sv
// Scoreboard bench for v_mult_addsub_pipe (default parameters).
`timescale 1ns/1ps
module tb_v_mult_addsub_pipe;

    localparam int unsigned Lat = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        add_sub = 1'b0;
    logic        accum = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic [15:0] c_in = '0;
    logic        out_valid;
    logic [15:0] res;
    logic        ovf;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_res = '0;

    v_mult_addsub_pipe #(
        .AW        (8),
        .BW        (8),
        .RW        (16),
        .IN_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .add_sub   (add_sub),
        .accum     (accum),
        .A         (a_in),
        .B         (b_in),
        .C         (c_in),
        .out_valid (out_valid),
        .RES       (res),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_out_valid: observed 1 expected 0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_res"}, {16'h0, res}, {16'h0, e.res});
                check({e.tag, "_ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
                check({e.tag, "_lat"}, cyc, e.cyc);
            end
        end
    end

    task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] c, input logic as, input logic ac,
                      input logic [15:0] er, input logic eo);
        exp_t e;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        c_in = c;
        add_sub = as;
        accum = ac;
        e.res = er;
        e.ovf = eo;
        e.cyc = cyc + Lat;
        e.tag = tag;
        exp_q.push_back(e);
        model_res = er;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic bubble(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_op(input int idx);
        logic [7:0]  a, b;
        logic [15:0] c, pr, r;
        logic [16:0] addend, s;
        logic        as, ac;
        a  = 8'($urandom);
        b  = 8'($urandom);
        c  = 16'($urandom);
        as = 1'($urandom);
        ac = 1'($urandom);
        pr = 16'(a) * 16'(b);
        addend = ac ? {1'b0, model_res} : {1'b0, c};
        s = as ? addend + {1'b0, pr} : addend - {1'b0, pr};
        r = s[15:0];
`ifdef V_MULT_ADDSUB_SAT_EN
        if (s[16]) r = as ? 16'hFFFF : 16'h0000;
`endif
        op($sformatf("rand%0d", idx), a, b, c, as, ac, r, s[16]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("reset_res", {16'h0, res}, 32'h0);
        check("reset_ovf", {31'h0, ovf}, 32'h0);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op("basic_add", 8'd3, 8'd4, 16'd10, 1'b1, 1'b0, 16'd22, 1'b0);
        bubble(4);
        op("basic_sub", 8'd2, 8'd5, 16'd100, 1'b0, 1'b0, 16'd90, 1'b0);
`ifdef V_MULT_ADDSUB_SAT_EN
        op("underflow", 8'd255, 8'd255, 16'd0, 1'b0, 1'b0, 16'h0000, 1'b1);
`else
        op("underflow", 8'd255, 8'd255, 16'd0, 1'b0, 1'b0, 16'h01FF, 1'b1);
`endif
        bubble(2);

        op("acc_start", 8'd1, 8'd1, 16'd0, 1'b1, 1'b0, 16'd1, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            op($sformatf("acc_b2b%0d", i), 8'd1, 8'd1, 16'hBEEF, 1'b1, 1'b1, 16'(i), 1'b0);
        end
        bubble(4);

        op("accbub_start", 8'd1, 8'd1, 16'd0, 1'b1, 1'b0, 16'd1, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            bubble(3);
            op($sformatf("accbub%0d", i), 8'd1, 8'd1, 16'h1234, 1'b1, 1'b1, 16'(i), 1'b0);
        end
        bubble(4);

        op("ovf_base", 8'd0, 8'd0, 16'hFF00, 1'b1, 1'b0, 16'hFF00, 1'b0);
        op("ovf_fill", 8'hF0, 8'd1, 16'd0, 1'b1, 1'b1, 16'hFFF0, 1'b0);
`ifdef V_MULT_ADDSUB_SAT_EN
        op("overflow", 8'd1, 8'd32, 16'd0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
`else
        op("overflow", 8'd1, 8'd32, 16'd0, 1'b1, 1'b1, 16'h0010, 1'b1);
`endif
        bubble(4);

        for (int i = 0; i < 16; i++) begin
            rand_op(i);
            if (i % 5 == 4) bubble(2);
        end
        bubble(5);

        // Two operands in flight, then a short reset pulse.
        op("flight1", 8'd7, 8'd9, 16'd5, 1'b1, 1'b0, 16'd68, 1'b0);
        op("flight2", 8'd2, 8'd2, 16'd1, 1'b1, 1'b0, 16'd5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_res", {16'h0, res}, 32'h0);
        check("midreset_out_valid", {31'h0, out_valid}, 32'h0);
        check("midreset_ovf", {31'h0, ovf}, 32'h0);
        exp_q.delete();
        model_res = '0;
        rst_n = 1'b1;
        #1;
        bubble(8);
        op("post_reset_add", 8'd3, 8'd4, 16'd10, 1'b1, 1'b0, 16'd22, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/v_mult_addsub_pipe.md
V_MULT_ADDSUB_PIPE -- requirements
Module: v_mult_addsub_pipe

Interface
REQ-001 SHALL have parameter AW, default 8: width of operand A.
REQ-002 SHALL have parameter BW, default 8: width of operand B.
REQ-003 SHALL have parameter RW, default 16: width of C and RES; legal range is RW >= AW+BW.
REQ-004 SHALL have parameter IN_STAGES, default 2: number of input register levels; legal range is 1..4.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the operand set on this cycle is live.
REQ-008 SHALL have port add_sub, input, 1 bit: 1 selects addend+product, 0 selects addend-product.
REQ-009 SHALL have port accum, input, 1 bit: 1 makes the addend the current RES, 0 makes it C.
REQ-010 SHALL have port A, input, AW bits: unsigned multiplicand.
REQ-011 SHALL have port B, input, BW bits: unsigned multiplier.
REQ-012 SHALL have port C, input, RW bits: unsigned addend.
REQ-013 SHALL have port out_valid, output, 1 bit: RES was updated on the last edge.
REQ-014 SHALL have port RES, output, RW bits: registered result.
REQ-015 SHALL have port ovf, output, 1 bit: carry-out (add) or borrow (sub) of the last update.

Function
REQ-016 SHALL delay A, B, C, add_sub, accum and in_valid through exactly IN_STAGES register levels, so that all six stay aligned (C is pipelined, not combinational).
REQ-017 SHALL form the product of the delayed A and B as an (AW+BW)-bit unsigned value, zero-extended to RW+1 bits.
REQ-018 SHALL take the addend as RES when the delayed accum is 1, else the delayed C; both are zero-extended to RW+1 bits.
REQ-019 SHALL compute the sum as addend+product or addend-product per the delayed add_sub, in RW+1 bits; bit RW is the carry or borrow.
REQ-020 SHALL, when the delayed valid is 1, register the low RW bits into RES, bit RW into ovf, and 1 into out_valid.
REQ-021 SHALL, when the delayed valid is 0, hold RES and ovf and drive out_valid to 0.
REQ-022 SHALL have a latency of IN_STAGES+1 edges from in_valid sampled high to out_valid high; throughput is one result per cycle.
REQ-023 SHALL, on back-to-back valid cycles with accum=1, use the RES written on the immediately preceding edge, with no stall.
REQ-024 SHALL NOT let bubble cycles (valid low) alter the accumulator; an accumulation may span any number of bubbles.

Reset
REQ-025 SHALL, while rst_n is low, immediately clear all pipeline registers, RES, ovf and out_valid to 0, regardless of clk.
REQ-026 SHALL discard any in-flight operands on a reset asserted mid-pipeline; the first out_valid after release follows a fresh in_valid by IN_STAGES+1 edges.

Configuration
REQ-027 SHALL, with V_MULT_ADDSUB_SAT_EN defined, clamp RES to all-ones on add carry and to zero on sub borrow, with ovf still set.
REQ-028 SHALL, without V_MULT_ADDSUB_SAT_EN defined, wrap RES modulo 2^RW, with ovf still set.

Structure
REQ-029 SHALL place the stage-count bounds and the saturation constants (all-ones, zero) in shared package v_mult_pkg.
REQ-030 SHALL implement the input delay line as one parametrised sub-module, v_pipe_delay (width, depth), instantiated once over the concatenated control and data bus.

Verification
REQ-031 SHALL cover basic add: A=3, B=4, C=10, add_sub=1, accum=0, IN_STAGES=2 -> out_valid high exactly 3 edges later, RES=22, ovf=0.
REQ-032 SHALL cover basic subtract: A=2, B=5, C=100, add_sub=0 -> RES=90, ovf=0.
REQ-033 SHALL cover underflow: A=255, B=255, C=0, add_sub=0 -> ovf=1; RES=0 with the macro, RES=0x01FF without it.
REQ-034 SHALL cover accumulate: C=0, A=1, B=1, accum=0 then four back-to-back cycles with accum=1, add_sub=1 -> RES sequence 1, 2, 3, 4, 5 on consecutive edges; inserting 3 bubbles between cycles gives the same final RES=5.
REQ-035 SHALL cover overflow: RES=0xFFF0 by accumulation, then A=1, B=32, accum=1, add_sub=1 -> ovf=1; RES=0xFFFF with the macro, RES=0x0010 without it.
REQ-036 SHALL cover reset mid-flight: drop rst_n for 1 ns while two operands are in the pipeline -> RES=0, out_valid=0 at once, and no out_valid follows for those operands.
